// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//   Load/store unit between the execute stage and a 32-bit word-addressed
//   data memory. Byte lanes are generated from funct3 and the low address
//   bits. A halfword or word access that crosses a word boundary is split
//   into two word beats. Load data is sign- or zero-extended on the way back.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready core request handshake; the core stalls while req_ready=0
//   req_we          1 = store, 0 = load
//   req_funct3      000 b, 001 h, 010 w, 100 bu, 101 hu (others illegal)
//   req_addr        effective byte address
//   req_wdata       store data, right-aligned
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load result (0 for stores and errors)
//   resp_err        illegal funct3, qualified by resp_valid
//   mem_req/ready   memory beat handshake
//   mem_we, mem_addr, mem_be, mem_wdata, mem_rdata   memory beat fields
//
// Handshakes: a request is taken on a rising edge where req_valid and
// req_ready are both 1. A memory beat completes on a rising edge where
// mem_req and mem_ready are both 1; until then every mem_* output holds.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  // Request latched at accept; every later output is derived from these.
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd0_q;
  logic [DATA_WIDTH-1:0] rd1_q;

  logic                    req_illegal;
  logic [1:0]              off;
  logic [3:0]              size_mask;
  logic [7:0]              mask;
  logic                    split;
  logic [2*DATA_WIDTH-1:0] wide_wdata;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [ADDR_WIDTH-1:0]   base_addr;

  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111);

  assign off = addr_q[1:0];

  always_comb begin
    size_mask = 4'b1111;
    case (f3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Eight-lane mask across two consecutive words; the upper nibble is the
  // second beat, so any bit set there means the access is split.
  assign mask       = {4'b0000, size_mask} << off;
  assign split      = |mask[7:4];
  assign wide_wdata = {{DATA_WIDTH{1'b0}}, wdata_q} << {off, 3'b000};
  assign base_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Lanes of both beats concatenated and shifted down; bytes beyond the
  // access size are dropped by the extension below.
  assign load_word = DATA_WIDTH'({rd1_q, rd0_q} >> {off, 3'b000});

  always_comb begin
    load_ext = '0;
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){load_word[15]}}, load_word[15:0]};
      3'b010:  load_ext = load_word;
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_word[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_word[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_illegal;
      end
      if (state == BEAT0 && mem_ready) rd0_q <= mem_rdata;
      if (state == BEAT1 && mem_ready) rd1_q <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_illegal ? RESP : BEAT0;
      BEAT0:   if (mem_ready) state_next = split ? BEAT1 : RESP;
      BEAT1:   if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on state and latched registers, never on mem_ready.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    case (state)
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr;
        mem_be    = mask[3:0];
        mem_wdata = wide_wdata[DATA_WIDTH-1:0];
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr + ADDR_WIDTH'(4);
        mem_be    = mask[7:4];
        mem_wdata = wide_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) resp_rdata = load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port
//   Bench for lsu_mem_port. A byte-array memory answers beats with random
//   (or planned) wait states. A separate reference byte array models what
//   memory should hold; expected beats and load results are computed from
//   the access rules byte by byte.
module tb_lsu_mem_port;

  localparam int BW = 69;  // {addr[31:0], be[3:0], we, wdata[31:0]}

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  lsu_mem_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- memories ----------------
  logic [7:0] mem_bytes [1024];   // what the responder serves
  logic [7:0] ref_bytes [1024];   // what memory should contain

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    mem_bytes[int'(a & 32'h3FF)] = v;
    ref_bytes[int'(a & 32'h3FF)] = v;
  endtask

  // ---------------- memory responder ----------------
  int              wait_plan[$];
  int              wait_left;
  int              wait_total;
  bit              armed;
  logic [BW-1:0]   snap;
  logic [BW-1:0]   exp_q[$];
  logic [BW-1:0]   obs_q[$];

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ready = 1'b0;
      armed     = 1'b0;
    end else begin
      if (!armed) begin
        armed = 1'b1;
        wait_left = (wait_plan.size() > 0) ? wait_plan.pop_front() : int'($urandom_range(0, 2));
        snap = {mem_addr, mem_be, mem_we, mem_wdata};
      end else begin
        check("mem_stable", {mem_addr, mem_be, mem_we, mem_wdata}, snap);
      end
      if (wait_left == 0) begin
        int wi;
        wi = int'(mem_addr & 32'h3FC);
        mem_ready = 1'b1;
        mem_rdata = {mem_bytes[wi+3], mem_bytes[wi+2], mem_bytes[wi+1], mem_bytes[wi]};
        obs_q.push_back({mem_addr, mem_be, mem_we,
                         mem_we ? (mem_wdata & lane_mask(mem_be)) : 32'h0});
        if (mem_we) begin
          for (int k = 0; k < 4; k++)
            if (mem_be[k]) mem_bytes[wi+k] = mem_wdata[8*k +: 8];
        end
        armed = 1'b0;
      end else begin
        mem_ready = 1'b0;
        wait_left--;
        wait_total++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit is_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int          n;
    v = 32'h0;
    n = size_of(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[int'((a + 32'(i)) & 32'h3FF)];
    case (f3)
      3'b000:  return 32'(int'($signed(v[7:0])));
      3'b001:  return 32'(int'($signed(v[15:0])));
      3'b100:  return 32'(v[7:0]);
      3'b101:  return 32'(v[15:0]);
      default: return v;
    endcase
  endfunction

  // Builds the expected beats byte by byte: each byte lands in the word
  // containing its address, consecutive bytes in one word share a beat.
  task automatic build_beats(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output int nb);
    logic [31:0] ea [2];
    logic [3:0]  eb [2];
    logic [31:0] ew [2];
    logic [31:0] ba, wa;
    nb = 0;
    for (int i = 0; i < size_of(f3); i++) begin
      ba = a + 32'(i);
      wa = {ba[31:2], 2'b00};
      if (nb == 0 || wa != ea[nb-1]) begin
        ea[nb] = wa; eb[nb] = 4'b0; ew[nb] = 32'h0; nb++;
      end
      eb[nb-1][ba[1:0]] = 1'b1;
      ew[nb-1][8*int'(ba[1:0]) +: 8] = wd[8*i +: 8];
    end
    for (int j = 0; j < nb; j++) exp_q.push_back({ea[j], eb[j], we, we ? ew[j] : 32'h0});
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    bit          ill;
    int          nb;
    int          n;
    int          lat;
    bit          busy_bad;
    logic [31:0] exp_rd;
    ill = is_illegal(f3);
    exp_q.delete();
    obs_q.delete();
    nb = 0;
    exp_rd = 32'h0;
    if (!ill) begin
      build_beats(we, f3, a, wd, nb);
      if (we) for (int i = 0; i < size_of(f3); i++)
        ref_bytes[int'((a + 32'(i)) & 32'h3FF)] = wd[8*i +: 8];
      else exp_rd = ref_load(f3, a);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    wait_total = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    while (!resp_valid && lat < 60) begin
      if (req_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (req_ready) busy_bad = 1'b1;
    check("resp_seen", resp_valid, 1'b1);
    check("latency", lat, 1 + nb + wait_total);
    check("ready_low_busy", busy_bad, 1'b0);
    check("resp_err", resp_err, ill);
    check("resp_rdata", resp_rdata, exp_rd);
    check("beat_count", obs_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++)
      check("beat", obs_q[j], exp_q[j]);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
    check("ready_after", req_ready, 1'b1);
  endtask

  // ---------------- main ----------------
  initial begin
    bit bad;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    wait_total = 0; wait_left = 0; armed = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem_bytes[i] = 8'($urandom);
      ref_bytes[i] = mem_bytes[i];
    end
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // aligned lw, zero wait
    set_byte(32'h100, 8'hEF); set_byte(32'h101, 8'hBE);
    set_byte(32'h102, 8'hAD); set_byte(32'h103, 8'hDE);
    wait_plan.push_back(0);
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    // lb / lbu of 0x80 at top lane
    set_byte(32'h103, 8'h80);
    do_req(1'b0, 3'b000, 32'h103, 32'h0);
    do_req(1'b0, 3'b100, 32'h103, 32'h0);
    // sh to upper half
    do_req(1'b1, 3'b001, 32'h102, 32'h1234ABCD);
    // misaligned lw, zero wait on both beats
    set_byte(32'h0FE, 8'hAA); set_byte(32'h0FF, 8'hBB);
    set_byte(32'h100, 8'hCC); set_byte(32'h101, 8'hDD);
    wait_plan.push_back(0); wait_plan.push_back(0);
    do_req(1'b0, 3'b010, 32'h0FE, 32'h0);
    // sw with three wait cycles
    wait_plan.push_back(3);
    do_req(1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
    do_req(1'b0, 3'b010, 32'h200, 32'h0);
    // illegal funct3
    do_req(1'b0, 3'b011, 32'h040, 32'h0);
    do_req(1'b0, 3'b110, 32'h040, 32'h0);
    do_req(1'b1, 3'b111, 32'h040, 32'h5555AAAA);
    // second beat wraps past the top of the address space
    do_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0);

    // reset while the second beat is waiting
    wait_plan.push_back(0); wait_plan.push_back(30);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h1FE; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_req_before", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", mem_req, 1'b0);
    check("rst_mid_ready", req_ready, 1'b1);
    bad = 1'b0;
    repeat (2) begin @(negedge clk); if (resp_valid || mem_req) bad = 1'b1; end
    rst_n = 1'b1;
    wait_plan.delete();
    repeat (3) begin @(negedge clk); if (resp_valid || mem_req || !req_ready) bad = 1'b1; end
    check("rst_mid_quiet", bad, 1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'($urandom_range(0, 1023));
      do_req(1'($urandom), 3'($urandom), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting between the core's control/execute stage and a 32-bit word-addressed data memory. It consumes the memory-side outputs of instruction decode (store/load request, funct3 addressing mode, effective address, store data) and performs the access using a valid/ready memory handshake. Byte lanes are generated and load data is sign- or zero-extended. Misaligned halfword/word accesses are split into two word beats. The core stalls while `req_ready` is low.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of `addr` and `mem_addr`
- `DATA_WIDTH`, 32, data width; only 32 is supported

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  core requests an access this cycle
- `req_ready`  out  1  unit idle and accepting; core stalls when low
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  addressing mode (000 b, 001 h, 010 w, 100 bu, 101 hu)
- `req_addr`  in  ADDR_WIDTH  effective byte address
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned
- `resp_valid`  out  1  one-cycle pulse, access complete
- `resp_rdata`  out  DATA_WIDTH  extended load result; 0 for stores/errors
- `resp_err`  out  1  illegal funct3, valid with `resp_valid`
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  beat is a write
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, `[1:0]` = 00
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  DATA_WIDTH  lane-aligned write data
- `mem_ready`  in  1  memory completes the beat this cycle
- `mem_rdata`  in  DATA_WIDTH  read word, valid when `mem_ready` is high on a read beat

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- `req_ready` = (state == IDLE).
- IDLE, `req_valid`=1: latch the request, compute the beats, go to BEAT0.
  - Illegal funct3 is 011, 110 or 111. Loads with 1xx are also illegal when the size is word, i.e. funct3 = 110.
  - On illegal funct3: go straight to RESP with `resp_err`=1 and no memory beat.
- Size: b = 1 byte, h = 2 bytes, w = 4 bytes. off = `addr[1:0]`. mask = ((1<<size)-1) << off, 8 bits wide.
- Split = mask[7:4] ≠ 0.
- BEAT0 signals:
  - `mem_addr` = {addr[ADDR_WIDTH-1:2], 00}
  - `mem_be` = mask[3:0]
  - `mem_wdata` = wdata << 8·off
- BEAT1 signals:
  - `mem_addr` = BEAT0 address + 4 (wraps modulo 2^ADDR_WIDTH)
  - `mem_be` = mask[7:4]
  - `mem_wdata` = wdata >> 8·(4−off)
- `mem_req` = 1 in BEAT0 and BEAT1, and is held until `mem_ready`. Address, BE, data and WE stay stable while `mem_req`=1 and `mem_ready`=0.
- BEAT0 with `mem_ready`: capture read bytes, then go to BEAT1 if split, else RESP.
- BEAT1 with `mem_ready`: capture the remaining bytes, then go to RESP.
- Load assembly: the byte lanes are concatenated as {beat1, beat0} >> 8·off and truncated to size.
  - funct3 000/001 sign-extend from bit 7/15.
  - funct3 100/101 zero-extend.
  - funct3 010 passes all 32 bits.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE. `resp_rdata`/`resp_err` are valid only in that cycle.
- Stores: `resp_rdata`=0.
- Requests arriving while `req_ready`=0 are ignored. The core holds its request until accepted.

## Timing
- Reset (async, `rst_n`=0):
  - state = IDLE
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `req_ready`=1
- Reset mid-beat: `mem_req` drops immediately, and the in-flight access is abandoned with no response.
- All memory-side and response outputs are registered or decoded from state only; no combinational path from `mem_ready` to outputs.
- Accept at edge N (IDLE, `req_valid`):
  - BEAT0 in cycle N+1.
  - With zero-wait memory, aligned access: RESP in N+2, `req_ready` again in N+3.
  - Split access: one cycle longer.
- Each memory wait cycle adds one cycle of latency.
- Illegal funct3: RESP in N+1.
- Back-to-back: a new request may be accepted in the first IDLE cycle after RESP.

## Test plan
- Aligned lw, addr 0x100, `mem_rdata`=0xDEADBEEF, zero wait:
  - one beat, `mem_addr` 0x100, `mem_be` 1111
  - `resp_rdata` 0xDEADBEEF two cycles after accept
- lb/lbu, addr 0x103, mem word 0x80xxxxxx:
  - `mem_be` 1000
  - lb gives 0xFFFFFF80, lbu gives 0x00000080
- sh, addr 0x102, wdata 0x1234ABCD: `mem_be` 1100, `mem_wdata` 0xABCD0000, `mem_we`=1, `resp_rdata` 0.
- Misaligned lw, addr 0x0FE:
  - beat0: 0x0FC, be 1100, rdata 0xBBAAxxxx
  - beat1: 0x100, be 0011, rdata 0xxxxxDDCC
  - `resp_rdata` 0xDDCCBBAA
- Wait states: hold `mem_ready`=0 for 3 cycles on sw.
  - `mem_req`/addr/data are stable throughout.
  - `req_ready` is 0 throughout.
  - `resp_valid` pulses once, exactly one cycle after `mem_ready`.
- Error and reset:
  - funct3 = 011 gives `resp_err`=1, no `mem_req`.
  - Asserting `rst_n`=0 during BEAT1 drops `mem_req` immediately, gives no `resp_valid`, and returns to IDLE.
